// File: rtl/div_iter_pkg.sv
// Shared definitions for the iterative divider.
//   divStateT : FSM encoding (IDLE, BUSY, DONE)
//   DIV_WIDTH : default operand width
package cpu_defs;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } divStateT;

endpackage

// File: rtl/div_iter_abs_fix.sv
// div_abs_fix: combinational conditional two's-complement negate.
// Conditions operands (absolute value) and fixes result signs.
//   value  in  WIDTH : input word
//   negate in  1     : 1 = return -value, 0 = pass through
//   result out WIDTH : value or its WIDTH-bit two's complement
module div_abs_fix
    import cpu_defs::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] value,
    input  logic             negate,
    output logic [WIDTH-1:0] result
);

    // Negation wraps at WIDTH bits, so -(-2^(WIDTH-1)) stays 0x80..0,
    // which is the correct magnitude when read as unsigned.
    assign result = negate ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/div_iter.sv
// div_iter: iterative radix-2 restoring divider for MIPS DIV/DIVU.
// One start cycle plus WIDTH iteration cycles; result = {remainder, quotient}.
//   clk           in  1       : pipeline clock
//   resetn        in  1       : asynchronous active-low reset
//   div_en        in  1       : DIV/DIVU sitting in E (level)
//   signed_div    in  1       : 1 = DIV, 0 = DIVU (sampled at start)
//   a, b          in  WIDTH   : dividend / divisor (sampled at start)
//   cancel        in  1       : exception flush, aborts everything
//   d_cache_stall in  1       : pipeline frozen this cycle
//   div_stall     out 1       : busy, feeds the hazard unit's ALU stall
//   div_ready     out 1       : result valid this cycle
//   result        out 2*WIDTH : {remainder, quotient}
module div_iter
    import cpu_defs::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               div_en,
    input  logic               signed_div,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               cancel,
    input  logic               d_cache_stall,
    output logic               div_stall,
    output logic               div_ready,
    output logic [2*WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH) + 1;

    divStateT           stateReg;
    divStateT           stateNext;
    logic [CW-1:0]      countReg;
    logic [WIDTH-1:0]   remReg;
    logic [WIDTH-1:0]   quoReg;
    logic [WIDTH-1:0]   divisorReg;
    logic               negQuoReg;
    logic               negRemReg;
    logic [2*WIDTH-1:0] resultReg;

    logic               startDiv;
    logic [WIDTH-1:0]   absA;
    logic [WIDTH-1:0]   absB;
    logic [WIDTH:0]     remShift;
    logic [WIDTH+1:0]   trial;
    logic               trialOk;
    logic [WIDTH-1:0]   remStep;
    logic [WIDTH-1:0]   quoStep;
    logic [WIDTH-1:0]   fixedQuo;
    logic [WIDTH-1:0]   fixedRem;

    assign startDiv = (stateReg == IDLE) && div_en && !cancel;

    // Operand conditioning: magnitudes for the unsigned core.
    div_abs_fix #(.WIDTH(WIDTH)) uAbsA (
        .value  (a),
        .negate (signed_div & a[WIDTH-1]),
        .result (absA)
    );

    div_abs_fix #(.WIDTH(WIDTH)) uAbsB (
        .value  (b),
        .negate (signed_div & b[WIDTH-1]),
        .result (absB)
    );

    // One restoring step. The dividend is kept in quoReg and shifted out of
    // its MSB into the partial remainder as quotient bits shift in at the LSB.
    // The shifted remainder needs WIDTH+1 bits (it can reach 2*divisor-1),
    // plus one more bit to read the borrow of the trial subtraction.
    // A zero divisor makes every trial succeed, which naturally yields
    // quotient = all ones and remainder = dividend.
    assign remShift = {remReg, quoReg[WIDTH-1]};
    assign trial    = {1'b0, remShift} - {2'b00, divisorReg};
    assign trialOk  = ~trial[WIDTH+1];
    assign remStep  = trialOk ? trial[WIDTH-1:0] : remShift[WIDTH-1:0];
    assign quoStep  = {quoReg[WIDTH-2:0], trialOk};

    // Sign fix-up applied to the final step's values as DONE is entered.
    div_abs_fix #(.WIDTH(WIDTH)) uFixQuo (
        .value  (quoStep),
        .negate (negQuoReg),
        .result (fixedQuo)
    );

    div_abs_fix #(.WIDTH(WIDTH)) uFixRem (
        .value  (remStep),
        .negate (negRemReg),
        .result (fixedRem)
    );

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    // Next-state logic; cancel overrides every transition.
    always_comb begin
        stateNext = stateReg;
        if (cancel) begin
            stateNext = IDLE;
        end else begin
            case (stateReg)
                IDLE:    if (div_en) stateNext = BUSY;
                BUSY:    if (countReg == CW'(1)) stateNext = DONE;
                // Leaving DONE only when the pipeline advances keeps a
                // frozen DIV from being started a second time.
                DONE:    if (!d_cache_stall) stateNext = IDLE;
                default: stateNext = IDLE;
            endcase
        end
    end

    // Output logic
    always_comb begin
        div_stall = 1'b0;
        div_ready = 1'b0;
        if (!cancel) begin
            case (stateReg)
                IDLE:    div_stall = div_en;
                BUSY:    div_stall = 1'b1;
                DONE:    div_ready = 1'b1;
                default: div_stall = 1'b0;
            endcase
        end
    end

    // Counter and datapath
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            countReg   <= '0;
            remReg     <= '0;
            quoReg     <= '0;
            divisorReg <= '0;
            negQuoReg  <= 1'b0;
            negRemReg  <= 1'b0;
            resultReg  <= '0;
        end else if (cancel) begin
            countReg <= '0;
        end else if (startDiv) begin
            countReg   <= CW'(WIDTH);
            remReg     <= '0;
            quoReg     <= absA;
            divisorReg <= absB;
            negQuoReg  <= signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
            negRemReg  <= signed_div & a[WIDTH-1];
        end else if (stateReg == BUSY) begin
            remReg   <= remStep;
            quoReg   <= quoStep;
            countReg <= countReg - CW'(1);
            if (countReg == CW'(1)) begin
                resultReg <= {fixedRem, fixedQuo};
            end
        end
    end

    assign result = resultReg;

endmodule

// File: tb/tb_div_iter.sv
module tb_div_iter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        div_en;
    logic        signed_div;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        d_cache_stall;
    logic        div_stall;
    logic        div_ready;
    logic [63:0] result;

    int errCount   = 0;
    int checkCount = 0;

    div_iter #(.WIDTH(32)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .div_en        (div_en),
        .signed_div    (signed_div),
        .a             (a),
        .b             (b),
        .cancel        (cancel),
        .d_cache_stall (d_cache_stall),
        .div_stall     (div_stall),
        .div_ready     (div_ready),
        .result        (result)
    );

    always #5 clk = ~clk;

    task automatic checkValue(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got !== exp) begin
            errCount++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Presents a division while in IDLE and counts stall cycles until
    // div_stall drops (bounded).
    task automatic startDiv(input logic sgn, input logic [31:0] av, input logic [31:0] bv,
                            output int stalls);
        div_en     = 1'b1;
        signed_div = sgn;
        a          = av;
        b          = bv;
        #1;
        stalls = 0;
        while (div_stall && stalls < 100) begin
            stalls++;
            nextCycle();
        end
    endtask

    // Instruction leaves E: drop div_en after the DONE cycle and expect IDLE.
    task automatic finishDiv(input string tag);
        nextCycle();
        div_en = 1'b0;
        #1;
        checkValue({tag, "_idle_ready"}, 64'(div_ready), 64'd0);
        checkValue({tag, "_idle_stall"}, 64'(div_stall), 64'd0);
    endtask

    task automatic runDiv(input string tag, input logic sgn, input logic [31:0] av,
                          input logic [31:0] bv, input logic [63:0] exp);
        int stalls;
        startDiv(sgn, av, bv, stalls);
        checkValue({tag, "_stall_cycles"}, 64'(stalls), 64'd33);
        checkValue({tag, "_ready"}, 64'(div_ready), 64'd1);
        checkValue({tag, "_result"}, result, exp);
        $display("div %s signed=%0d a=%h b=%h stalls=%0d result=%h", tag, sgn, av, bv, stalls, result);
        finishDiv(tag);
    endtask

    initial begin
        int  stalls;
        bit  readySeen;
        logic [63:0] heldExp;

        resetn        = 1'b0;
        div_en        = 1'b0;
        signed_div    = 1'b0;
        a             = '0;
        b             = '0;
        cancel        = 1'b0;
        d_cache_stall = 1'b0;
        #12;
        checkValue("reset_stall",  64'(div_stall), 64'd0);
        checkValue("reset_ready",  64'(div_ready), 64'd0);
        checkValue("reset_result", result, 64'd0);
        resetn = 1'b1;
        nextCycle();

        // Basic and signed cases
        runDiv("divu_100_7",   1'b0, 32'd100,        32'd7,        {32'd2,        32'd14});
        runDiv("div_m7_2",     1'b1, 32'hFFFFFFF9,   32'd2,        {32'hFFFFFFFF, 32'hFFFFFFFD});
        runDiv("div_7_m2",     1'b1, 32'd7,          32'hFFFFFFFE, {32'd1,        32'hFFFFFFFD});
        runDiv("divu_m7_2",    1'b0, 32'hFFFFFFF9,   32'd2,        {32'd1,        32'h7FFFFFFC});
        runDiv("div_min_m1",   1'b1, 32'h80000000,   32'hFFFFFFFF, {32'd0,        32'h80000000});
        runDiv("divu_max_16",  1'b0, 32'hFFFFFFFF,   32'd16,       {32'd15,       32'h0FFFFFFF});
        // Divide by zero
        runDiv("divu_by_zero", 1'b0, 32'h12345678,   32'd0,        {32'h12345678, 32'hFFFFFFFF});
        runDiv("div_m5_zero",  1'b1, 32'hFFFFFFFB,   32'd0,        {32'hFFFFFFFB, 32'h00000001});

        // Cancel at BUSY cycle 10
        div_en     = 1'b1;
        signed_div = 1'b1;
        a          = 32'd100;
        b          = 32'd7;
        #1;
        checkValue("cancel_start_stall", 64'(div_stall), 64'd1);
        readySeen = 1'b0;
        repeat (10) begin
            nextCycle();
            if (div_ready) readySeen = 1'b1;
        end
        cancel = 1'b1;
        #1;
        checkValue("cancel_cycle_stall", 64'(div_stall), 64'd0);
        checkValue("cancel_cycle_ready", 64'(div_ready), 64'd0);
        nextCycle();
        cancel = 1'b0;
        div_en = 1'b0;
        #1;
        checkValue("cancel_idle_stall", 64'(div_stall), 64'd0);
        repeat (3) begin
            nextCycle();
            if (div_ready) readySeen = 1'b1;
        end
        checkValue("cancel_no_ready", 64'(readySeen), 64'd0);
        $display("div cancel at busy cycle 10 ready_seen=%0d", readySeen);
        runDiv("after_cancel", 1'b0, 32'd1000, 32'd33, {32'd10, 32'd30});

        // DONE held by d_cache_stall for 5 cycles with div_en still high
        heldExp = {32'd2, 32'd14};
        startDiv(1'b0, 32'd100, 32'd7, stalls);
        checkValue("hold_stall_cycles", 64'(stalls), 64'd33);
        d_cache_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checkValue("hold_ready",  64'(div_ready), 64'd1);
            checkValue("hold_stall",  64'(div_stall), 64'd0);
            checkValue("hold_result", result, heldExp);
            if (i < 4) nextCycle();
        end
        d_cache_stall = 1'b0;
        #1;
        checkValue("hold_release_ready", 64'(div_ready), 64'd1);
        $display("div held in DONE 5 cycles result=%h", result);
        finishDiv("hold");

        // Asynchronous reset at BUSY cycle 20
        div_en     = 1'b1;
        signed_div = 1'b0;
        a          = 32'd1000;
        b          = 32'd7;
        repeat (21) nextCycle();
        checkValue("pre_reset_busy", 64'(div_stall), 64'd1);
        resetn = 1'b0;
        div_en = 1'b0;
        #1;
        checkValue("async_reset_stall",  64'(div_stall), 64'd0);
        checkValue("async_reset_ready",  64'(div_ready), 64'd0);
        checkValue("async_reset_result", result, 64'd0);
        $display("div async reset at busy cycle 20 result=%h", result);
        nextCycle();
        resetn = 1'b1;
        nextCycle();
        runDiv("divu_9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3});

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
